harmonic_mean_seq: RTL and testbench
====================================

# harmonic_mean_seq

Parametrised N-channel harmonic-mean engine, the successor to the fixed four-input harmonic mean block. It captures one sample per channel when all channels are valid and computes HM = CHANNELS / Σ(1/xᵢ) in fixed point with a single shared sequential divider. It sits downstream of the per-channel sample sources and reports a one-cycle result strobe, a busy flag and a divide-by-zero error flag.

## Interface
- `WIDTH`, 16, sample and result width (unsigned)
- `CHANNELS`, 4, number of input channels, ≥2
- `FRAC`, 16, fractional bits of reciprocals; unit value is 2^FRAC
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high
- `data` input CHANNELS*WIDTH: packed samples; channel i in bits [i*WIDTH +: WIDTH]
- `data_valid` input CHANNELS: per-channel valid
- `harmonic_mean` output WIDTH: result, held until next result
- `data_ready` output 1: one-cycle strobe, result/error valid
- `busy` output 1: high from capture until the cycle of data_ready
- `error` output 1: a captured sample was zero; updated with each data_ready

## Operation
- Derived widths: DW = FRAC + clog2(CHANNELS) + 1; DIVW = max(DW, WIDTH). Accumulator is DW bits.
- States: IDLE, RECIP, FINAL, DONE.
- IDLE: when &data_valid, capture all samples, clear accumulator, channel index k=0, set busy. If any captured sample is 0, go to DONE with error=1 and result 0. Otherwise go to RECIP. Inputs are ignored while busy, with no queueing.
- RECIP: divide 2^FRAC by x_k to get R_k = floor(2^FRAC/x_k). On divider done, add R_k to the accumulator S. Advance k, or go to FINAL after k = CHANNELS-1.
- FINAL: divide CHANNELS·2^FRAC by S to get Q. On done, harmonic_mean = (Q > 2^WIDTH-1) ? 2^WIDTH-1 : Q[WIDTH-1:0], error=0. Go to DONE.
- DONE: data_ready=1 for this cycle, busy=0, return to IDLE. A new capture is possible on the next cycle.
- All arithmetic is unsigned and truncating (floor). S cannot overflow DW bits.
- Reset (async, any state): state=IDLE; harmonic_mean=0, data_ready=0, busy=0, error=0; divider aborted.

## Timing
- Divider: restoring, 1 quotient bit per cycle. It takes a one-cycle start, then DIVW iteration cycles, and raises done on the last iteration cycle. Each division therefore costs DIVW+1 cycles.
- Normal latency, from the capture edge to the data_ready cycle: (CHANNELS+1)·(DIVW+1) + 1 cycles. The defaults give 101 cycles.
- Zero-sample latency: data_ready is asserted in the cycle after capture.
- busy rises in the cycle after the capture edge and falls with data_ready.
- Minimum spacing between captures is latency + 1 cycles.

## Structure
- Package `harmonic_mean_pkg` holds:
  - the state enum (IDLE/RECIP/FINAL/DONE)
  - functions clog2 and max
  - localparam derivation helpers for DW/DIVW
- Sub-module `seq_divider`: parameter DIVW. Ports clk, reset, start, dividend, divisor, quotient, done, busy. Divisor 0 is never issued by the parent.
- The top level holds the FSM, capture registers, the channel mux into the divider, the accumulator and saturation.

## Test plan
- All four samples = 100 -> R=655 each, S=2620, result 100, error=0, data_ready exactly 101 cycles after capture.
- Samples 1, 2, 4, 8 -> S=122880, result 2.
- Samples 10, 20, 30, 40 -> S=13651, result 19.
- All samples = 65535 -> R=1 each, S=4, Q=65536, saturated result 65535.
- Channel 2 = 0, others 50 -> result 0, error=1, data_ready in the cycle after capture. A following all-50 capture -> result 50, error=0.
- Reset asserted mid-RECIP with a new valid set held during busy -> outputs zero immediately and no stale data_ready. Valids during busy are ignored. After reset release, a capture of all 7 -> result 7 after 101 cycles.

Source files
------------

// File: rtl/harmonic_mean_pkg.sv
// harmonic_mean_pkg
// Shared definitions for the N-channel harmonic-mean engine:
//   - hm_state_t  : controller states (IDLE, RECIP, FINAL, DONE)
//   - clog2, max  : elaboration-time helpers
//   - calc_dw     : accumulator width (reciprocal bits + channel growth + 1)
//   - calc_divw   : divider datapath width, wide enough for both the
//                   accumulator and a raw sample
package harmonic_mean_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECIP = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } hm_state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The sum of CHANNELS reciprocals, each at most 2^frac, fits here, and so
  // does the final dividend CHANNELS * 2^frac.
  function automatic int calc_dw(input int frac, input int channels);
    return frac + clog2(channels) + 1;
  endfunction

  function automatic int calc_divw(input int frac, input int channels, input int width);
    return max(calc_dw(frac, channels), width);
  endfunction

endpackage

// File: rtl/harmonic_mean_seq_divider.sv
// seq_divider
// Unsigned restoring divider, one quotient bit per clock.
// A start pulse loads the operands; DIVW iteration cycles follow and done is
// raised during the last of them, so a division occupies DIVW+1 cycles.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset (aborts)
//   start               : load dividend/divisor and begin (ignored while busy)
//   dividend, divisor   : DIVW-bit unsigned operands; divisor must be nonzero
//   quotient            : final quotient, valid while done is high
//   done                : high in the last iteration cycle
//   busy                : iteration in progress
module seq_divider
  import harmonic_mean_pkg::*;
#(
  parameter int DIVW = 19
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DIVW-1:0] dividend,
  input  logic [DIVW-1:0] divisor,
  output logic [DIVW-1:0] quotient,
  output logic            done,
  output logic            busy
);

  localparam int CW = clog2(DIVW + 1);

  logic [DIVW-1:0] rem;
  logic [DIVW-1:0] quo;
  logic [DIVW-1:0] dvs;
  logic [CW-1:0]   count;
  logic            active;

  logic [DIVW:0]   rem_shift;
  logic [DIVW:0]   diff;
  logic            fits;
  logic [DIVW-1:0] next_rem;
  logic [DIVW-1:0] next_quo;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The dividend bits are consumed from
  // the top of quo while quotient bits enter at the bottom. The quotient
  // port shows the post-step value so the parent can take the result in the
  // same cycle done is high.
  always_comb begin
    rem_shift = {rem, quo[DIVW-1]};
    diff      = rem_shift - {1'b0, dvs};
    fits      = (rem_shift >= {1'b0, dvs});
    next_rem  = fits ? diff[DIVW-1:0] : rem_shift[DIVW-1:0];
    next_quo  = {quo[DIVW-2:0], fits};
    quotient  = next_quo;
    done      = active && (count == CW'(1));
    busy      = active;
  end

  // Operand load on start, then one iteration per cycle until the bit
  // counter runs out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (start && !active) begin
      rem    <= '0;
      quo    <= dividend;
      dvs    <= divisor;
      count  <= CW'(DIVW);
      active <= 1'b1;
    end else if (active) begin
      rem   <= next_rem;
      quo   <= next_quo;
      count <= count - CW'(1);
      if (count == CW'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/harmonic_mean_seq.sv
// harmonic_mean_seq
// N-channel harmonic mean HM = CHANNELS / sum(1/x_i) in fixed point, using
// one shared sequential divider: CHANNELS reciprocal divisions followed by
// one final division.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   data           : packed samples, channel i at [i*WIDTH +: WIDTH]
//   data_valid     : per-channel valid; capture happens when all are high
//   harmonic_mean  : result, held until the next result
//   data_ready     : one-cycle strobe, harmonic_mean/error valid
//   busy           : computation in progress
//   error          : the last capture contained a zero sample
module harmonic_mean_seq
  import harmonic_mean_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int FRAC     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [CHANNELS-1:0]       data_valid,
  output logic [WIDTH-1:0]          harmonic_mean,
  output logic                      data_ready,
  output logic                      busy,
  output logic                      error
);

  localparam int DW   = calc_dw(FRAC, CHANNELS);
  localparam int DIVW = calc_divw(FRAC, CHANNELS, WIDTH);
  localparam int KW   = max(clog2(CHANNELS), 1);

  localparam logic [DIVW-1:0] UNIT       = DIVW'(1) << FRAC;
  localparam logic [DIVW-1:0] CHAN_UNIT  = DIVW'(CHANNELS) << FRAC;
  localparam logic [DIVW-1:0] SAT_LIMIT  = DIVW'({WIDTH{1'b1}});

  hm_state_t state;
  hm_state_t next_state;

  logic [CHANNELS*WIDTH-1:0] sample_reg;
  logic [KW-1:0]             k;
  logic [DW-1:0]             acc;
  logic [WIDTH-1:0]          cur_sample;
  logic                      any_zero;
  logic                      capture;
  logic                      last_channel;

  logic                      div_start;
  logic [DIVW-1:0]           div_dividend;
  logic [DIVW-1:0]           div_divisor;
  logic [DIVW-1:0]           div_quotient;
  logic                      div_done;
  logic                      div_busy;

  seq_divider #(
    .DIVW (DIVW)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done),
    .busy     (div_busy)
  );

  // Zero detection looks at the live inputs so the error path can be taken
  // on the capture edge itself.
  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (data[i*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
    end
  end

  assign capture      = (state == IDLE) && (&data_valid);
  assign cur_sample   = sample_reg[k*WIDTH +: WIDTH];
  assign last_channel = (k == KW'(CHANNELS - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and controller outputs. A division is launched whenever the
  // controller needs one and the divider is idle; the divider drops busy on
  // the edge that ends its done cycle, so the next division starts right
  // after the previous one without an extra handshake.
  always_comb begin
    next_state   = state;
    data_ready   = 1'b0;
    busy         = 1'b0;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    case (state)
      IDLE: begin
        if (capture) next_state = any_zero ? DONE : RECIP;
      end
      RECIP: begin
        busy         = 1'b1;
        div_start    = !div_busy;
        div_dividend = UNIT;
        div_divisor  = DIVW'(cur_sample);
        if (div_done && last_channel) next_state = FINAL;
      end
      FINAL: begin
        busy         = 1'b1;
        div_start    = !div_busy;
        div_dividend = CHAN_UNIT;
        div_divisor  = DIVW'(acc);
        if (div_done) next_state = DONE;
      end
      DONE: begin
        data_ready = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: sample capture, reciprocal accumulation and the saturated
  // final result. Inputs are only looked at in IDLE, so valids arriving
  // while a computation runs are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_reg    <= '0;
      k             <= '0;
      acc           <= '0;
      harmonic_mean <= '0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            sample_reg <= data;
            acc        <= '0;
            k          <= '0;
            if (any_zero) begin
              harmonic_mean <= '0;
              error         <= 1'b1;
            end
          end
        end
        RECIP: begin
          if (div_done) begin
            acc <= acc + DW'(div_quotient);
            if (!last_channel) k <= k + KW'(1);
          end
        end
        FINAL: begin
          if (div_done) begin
            harmonic_mean <= (div_quotient > SAT_LIMIT) ? {WIDTH{1'b1}}
                                                         : div_quotient[WIDTH-1:0];
            error         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_mean_seq.sv
// tb_harmonic_mean_seq
// Directed bench for harmonic_mean_seq with default parameters. Expected
// results come from an integer reference model and are queued at capture
// time; each data_ready pops one entry and checks result, error, latency
// and the busy/strobe behaviour.
module tb_harmonic_mean_seq;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int FRAC     = 16;
  localparam int DW       = FRAC + $clog2(CHANNELS) + 1;
  localparam int DIVW     = (DW > WIDTH) ? DW : WIDTH;
  localparam int LATENCY  = (CHANNELS + 1) * (DIVW + 1) + 1;
  localparam int TIMEOUT  = 400;

  typedef int unsigned samples_t [CHANNELS];

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             err;
    int               cap_cyc;
    int               latency;
  } expect_t;

  expect_t sb[$];

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [CHANNELS*WIDTH-1:0] data = '0;
  logic [CHANNELS-1:0]       data_valid = '0;
  logic [WIDTH-1:0]          harmonic_mean;
  logic                      data_ready;
  logic                      busy;
  logic                      error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  harmonic_mean_seq #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .FRAC     (FRAC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data          (data),
    .data_valid    (data_valid),
    .harmonic_mean (harmonic_mean),
    .data_ready    (data_ready),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: floor reciprocals summed, then floor final quotient, saturated.
  function automatic expect_t model(input samples_t x);
    expect_t         e;
    longint unsigned s;
    longint unsigned q;
    e.err     = 1'b0;
    e.cap_cyc = 0;
    s         = 0;
    q         = 0;
    foreach (x[i]) if (x[i] == 0) e.err = 1'b1;
    if (e.err) begin
      e.result  = '0;
      e.latency = 1;
    end else begin
      foreach (x[i]) s += (longint'(1) << FRAC) / x[i];
      q = (longint'(CHANNELS) << FRAC) / s;
      e.result  = (q > longint'((1 << WIDTH) - 1)) ? {WIDTH{1'b1}} : q[WIDTH-1:0];
      e.latency = LATENCY;
    end
    return e;
  endfunction

  // Drive one capture; optionally keep the valids high (with other data)
  // for hold cycles while the engine is busy.
  task automatic applyStimulus(input samples_t x, input int hold);
    expect_t e;
    @(negedge clk);
    for (int i = 0; i < CHANNELS; i++) data[i*WIDTH +: WIDTH] = WIDTH'(x[i]);
    data_valid = '1;
    @(posedge clk);
    #1;
    e         = model(x);
    e.cap_cyc = cyc;
    sb.push_back(e);
    if (!e.err) compare("busy_rise", {31'd0, busy}, 32'd1);
    if (hold > 0) begin
      data = ~data;
      repeat (hold) @(posedge clk);
      #1;
    end
    data_valid = '0;
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    int      waited;
    waited = 0;
    while (data_ready !== 1'b1 && waited < TIMEOUT) begin
      @(posedge clk);
      #1;
      waited++;
    end
    compare({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
    compare({tag, "_queued"}, {31'd0, (sb.size() > 0)}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare({tag, "_result"}, {16'd0, harmonic_mean}, {16'd0, e.result});
      compare({tag, "_error"}, {31'd0, error}, {31'd0, e.err});
      compare({tag, "_latency"}, cyc - e.cap_cyc + 1, e.latency);
      compare({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      compare({tag, "_strobe_len"}, {31'd0, data_ready}, 32'd0);
    end
  endtask

  task automatic expectQuiet(input string tag, input int cycles);
    int strobes;
    strobes = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (data_ready === 1'b1) strobes++;
    end
    compare(tag, strobes, 0);
  endtask

  initial begin
    samples_t s;

    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_hm", {16'd0, harmonic_mean}, 32'd0);
    compare("reset_ready", {31'd0, data_ready}, 32'd0);
    compare("reset_busy", {31'd0, busy}, 32'd0);
    compare("reset_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    s = '{100, 100, 100, 100};
    applyStimulus(s, 0);
    checkOutput("all100");

    s = '{1, 2, 4, 8};
    applyStimulus(s, 0);
    checkOutput("pow2");

    s = '{10, 20, 30, 40};
    applyStimulus(s, 40);
    checkOutput("ramp_held_valid");
    expectQuiet("ignored_valid", 30);

    s = '{65535, 65535, 65535, 65535};
    applyStimulus(s, 0);
    checkOutput("saturate");

    s = '{50, 50, 0, 50};
    applyStimulus(s, 0);
    checkOutput("zero_ch2");

    s = '{50, 50, 50, 50};
    applyStimulus(s, 0);
    checkOutput("all50");

    s = '{20, 20, 20, 20};
    applyStimulus(s, 0);
    @(negedge clk);
    for (int i = 0; i < CHANNELS; i++) data[i*WIDTH +: WIDTH] = WIDTH'(99);
    data_valid = '1;
    repeat (25) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    compare("midrun_reset_hm", {16'd0, harmonic_mean}, 32'd0);
    compare("midrun_reset_ready", {31'd0, data_ready}, 32'd0);
    compare("midrun_reset_busy", {31'd0, busy}, 32'd0);
    compare("midrun_reset_error", {31'd0, error}, 32'd0);
    sb.delete();
    @(negedge clk);
    data_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    expectQuiet("no_stale_ready", 150);

    s = '{7, 7, 7, 7};
    applyStimulus(s, 0);
    checkOutput("all7");

    $display("[TB] directed sequence complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
